// File: rtl/branch_ctrl_pkg.sv
// Shared types and constants for the decode-stage branch controller and the
// branch resolution unit.
package branch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STALL,
    ST_RESOLVE
  } bctl_state_t;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_t;

  // Branch codes understood by the resolution unit.
  localparam logic [5:0] BR_BEQ  = 6'h03;
  localparam logic [5:0] BR_BNE  = 6'h04;
  localparam logic [5:0] BR_BLEZ = 6'h07;
  localparam logic [5:0] BR_BGTZ = 6'h0F;
  localparam logic [5:0] BR_BGEZ = 6'h11;
  localparam logic [5:0] BR_BLTZ = 6'h13;

  function automatic logic [1:0] max_stall(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/branch_hazard_detect.sv
// Per-operand hazard check: how many cycles this branch operand must wait,
// and where it can be forwarded from once it is ready.
module branch_hazard_detect
  import branch_ctrl_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] src,
  input  logic             used,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             mem_reg_write,
  input  logic             mem_mem_read,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             wb_reg_write,
  input  logic [REG_W-1:0] wb_rd,
  output logic [1:0]       stall_req,
  output logic [1:0]       fwd_sel
);

  // r0 is hard-wired to zero, so it never depends on a producer.
  logic live;
  assign live = used && (src != '0);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    stall_req = 2'd0;
    fwd_sel   = FWD_RF;
    if (live) begin
      if (ex_mem_read && (ex_rd == src))
        stall_req = 2'd2;
      else if (ex_reg_write && (ex_rd == src))
        stall_req = 2'd1;
      else if (mem_mem_read && (mem_rd == src))
        stall_req = 2'd1;

      if (mem_reg_write && !mem_mem_read && (mem_rd == src))
        fwd_sel = FWD_EXMEM;
      else if (wb_reg_write && (wb_rd == src))
        fwd_sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/branch_ctrl.sv
// Decode-stage branch controller: stalls on unforwardable branch operands,
// enables resolution, redirects/flushes on taken, and counts statistics.
module branch_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int REG_W  = 5,
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_branch,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic              id_uses_rt,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic [REG_W-1:0]  ex_rd,
  input  logic              mem_reg_write,
  input  logic              mem_mem_read,
  input  logic [REG_W-1:0]  mem_rd,
  input  logic              wb_reg_write,
  input  logic [REG_W-1:0]  wb_rd,
  input  logic              bru_taken,
  output logic              bru_enable,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              stall_front,
  output logic              bubble_id_ex,
  output logic              pc_sel_branch,
  output logic              flush_if_id,
  output logic [STAT_W-1:0] cnt_branches,
  output logic [STAT_W-1:0] cnt_taken,
  output logic [STAT_W-1:0] cnt_stall_cycles
);

  logic [1:0] stall_a, stall_b, req_stall;
  logic [1:0] hz_fwd_a, hz_fwd_b;

  branch_hazard_detect #(.REG_W(REG_W)) u_hz_a (
    .src(id_rs), .used(1'b1),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read), .mem_rd(mem_rd),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
    .stall_req(stall_a), .fwd_sel(hz_fwd_a)
  );

  branch_hazard_detect #(.REG_W(REG_W)) u_hz_b (
    .src(id_rt), .used(id_uses_rt),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read), .mem_rd(mem_rd),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
    .stall_req(stall_b), .fwd_sel(hz_fwd_b)
  );

  assign req_stall = max_stall(stall_a, stall_b);

  bctl_state_t       state_q, state_d;
  logic [1:0]        stall_cnt_q, stall_cnt_d;
  logic [STAT_W-1:0] cnt_branches_q, cnt_branches_d;
  logic [STAT_W-1:0] cnt_taken_q, cnt_taken_d;
  logic [STAT_W-1:0] cnt_stall_q, cnt_stall_d;
  logic              do_resolve, in_stall;

  always_comb begin
    state_d        = state_q;
    stall_cnt_d    = stall_cnt_q;
    cnt_branches_d = cnt_branches_q;
    cnt_taken_d    = cnt_taken_q;
    cnt_stall_d    = cnt_stall_q;
    do_resolve     = 1'b0;
    in_stall       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (id_branch) begin
          if (req_stall == 2'd0) begin
            do_resolve = 1'b1;
          end else begin
            stall_cnt_d = req_stall;
            state_d     = ST_STALL;
          end
        end
      end
      ST_STALL: begin
        // A dropped id_branch means the branch was flushed from ID underneath us.
        if (!id_branch) begin
          stall_cnt_d = 2'd0;
          state_d     = ST_IDLE;
        end else begin
          in_stall    = 1'b1;
          stall_cnt_d = stall_cnt_q - 2'd1;
          if (stall_cnt_q == 2'd1) state_d = ST_RESOLVE;
        end
      end
      ST_RESOLVE: begin
        do_resolve = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (do_resolve) begin
      if (cnt_branches_q != '1) cnt_branches_d = cnt_branches_q + 1'b1;
      if (bru_taken && (cnt_taken_q != '1)) cnt_taken_d = cnt_taken_q + 1'b1;
    end
    if (in_stall && (cnt_stall_q != '1)) cnt_stall_d = cnt_stall_q + 1'b1;

    // Control outputs stay quiet while reset is held.
    bru_enable    = do_resolve && !rst;
    pc_sel_branch = do_resolve && !rst && bru_taken;
    flush_if_id   = do_resolve && !rst && bru_taken;
    fwd_a_sel     = (do_resolve && !rst) ? hz_fwd_a : FWD_RF;
    fwd_b_sel     = (do_resolve && !rst) ? hz_fwd_b : FWD_RF;
    stall_front   = in_stall && !rst;
    bubble_id_ex  = in_stall && !rst;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q        <= ST_IDLE;
      stall_cnt_q    <= 2'd0;
      cnt_branches_q <= '0;
      cnt_taken_q    <= '0;
      cnt_stall_q    <= '0;
    end else begin
      state_q        <= state_d;
      stall_cnt_q    <= stall_cnt_d;
      cnt_branches_q <= cnt_branches_d;
      cnt_taken_q    <= cnt_taken_d;
      cnt_stall_q    <= cnt_stall_d;
    end
  end

  assign cnt_branches     = cnt_branches_q;
  assign cnt_taken        = cnt_taken_q;
  assign cnt_stall_cycles = cnt_stall_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed bench for branch_ctrl: each step drives one cycle of pipeline
// context, queues the expected response and compares it at the falling edge.
module tb_branch_ctrl;
  import branch_ctrl_pkg::*;

  localparam int REG_W  = 5;
  localparam int STAT_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              id_branch, id_uses_rt;
  logic [REG_W-1:0]  id_rs, id_rt;
  logic              ex_reg_write, ex_mem_read, mem_reg_write, mem_mem_read, wb_reg_write;
  logic [REG_W-1:0]  ex_rd, mem_rd, wb_rd;
  logic              bru_taken;
  logic              bru_enable, stall_front, bubble_id_ex, pc_sel_branch, flush_if_id;
  logic [1:0]        fwd_a_sel, fwd_b_sel;
  logic [STAT_W-1:0] cnt_branches, cnt_taken, cnt_stall_cycles;

  branch_ctrl #(.REG_W(REG_W), .STAT_W(STAT_W)) dut (
    .clk(clk), .rst(rst), .id_branch(id_branch), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_rd(ex_rd), .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
    .mem_rd(mem_rd), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .bru_taken(bru_taken),
    .bru_enable(bru_enable), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .stall_front(stall_front), .bubble_id_ex(bubble_id_ex), .pc_sel_branch(pc_sel_branch),
    .flush_if_id(flush_if_id), .cnt_branches(cnt_branches), .cnt_taken(cnt_taken),
    .cnt_stall_cycles(cnt_stall_cycles)
  );

  always #5 clk = ~clk;

  typedef enum {EV_NONE, EV_STALL, EV_RESOLVE} ev_t;
  localparam int P_NONE = 0, P_ALU = 1, P_LOAD = 2;

  typedef struct {
    string             tag;
    logic              en, stall, pc;
    logic [1:0]        fa, fb;
    logic [STAT_W-1:0] br, tk, st;
  } exp_t;

  exp_t              sb_q[$];
  int                n_cmp = 0;
  int                n_fail = 0;
  logic [STAT_W-1:0] m_br, m_tk, m_st;

  function automatic logic [STAT_W-1:0] sat(input logic [STAT_W-1:0] v);
    return (v == {STAT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  task automatic check(input string tag, input string fld, input logic [15:0] obs, input logic [15:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, obs, expv);
    end
  endtask

  task automatic step(input string tag, input logic r, input logic br,
                      input logic [REG_W-1:0] rs, input logic [REG_W-1:0] rt, input logic urt,
                      input int exk, input logic [REG_W-1:0] exr,
                      input int memk, input logic [REG_W-1:0] memr,
                      input logic wbw, input logic [REG_W-1:0] wbr,
                      input logic tk, input ev_t ev, input logic [1:0] fa, input logic [1:0] fb);
    exp_t e;
    exp_t got;
    @(posedge clk);
    #1;
    rst = r; id_branch = br; id_rs = rs; id_rt = rt; id_uses_rt = urt;
    ex_reg_write = (exk != P_NONE); ex_mem_read = (exk == P_LOAD); ex_rd = exr;
    mem_reg_write = (memk != P_NONE); mem_mem_read = (memk == P_LOAD); mem_rd = memr;
    wb_reg_write = wbw; wb_rd = wbr; bru_taken = tk;

    e.tag   = tag;
    e.en    = (ev == EV_RESOLVE);
    e.stall = (ev == EV_STALL);
    e.pc    = (ev == EV_RESOLVE) && tk;
    e.fa    = (ev == EV_RESOLVE) ? fa : 2'b00;
    e.fb    = (ev == EV_RESOLVE) ? fb : 2'b00;
    e.br    = m_br;
    e.tk    = m_tk;
    e.st    = m_st;
    sb_q.push_back(e);

    if (r) begin
      m_br = '0; m_tk = '0; m_st = '0;
    end else if (ev == EV_STALL) begin
      m_st = sat(m_st);
    end else if (ev == EV_RESOLVE) begin
      m_br = sat(m_br);
      if (tk) m_tk = sat(m_tk);
    end

    @(negedge clk);
    got = sb_q.pop_front();
    check(got.tag, "bru_enable",   16'(bru_enable),       16'(got.en));
    check(got.tag, "fwd_a_sel",    16'(fwd_a_sel),        16'(got.fa));
    check(got.tag, "fwd_b_sel",    16'(fwd_b_sel),        16'(got.fb));
    check(got.tag, "stall_front",  16'(stall_front),      16'(got.stall));
    check(got.tag, "bubble_id_ex", 16'(bubble_id_ex),     16'(got.stall));
    check(got.tag, "pc_sel",       16'(pc_sel_branch),    16'(got.pc));
    check(got.tag, "flush_if_id",  16'(flush_if_id),      16'(got.pc));
    check(got.tag, "cnt_branches", 16'(cnt_branches),     16'(got.br));
    check(got.tag, "cnt_taken",    16'(cnt_taken),        16'(got.tk));
    check(got.tag, "cnt_stall",    16'(cnt_stall_cycles), 16'(got.st));
  endtask

  initial begin
    rst = 1'b1; id_branch = 1'b0; id_rs = '0; id_rt = '0; id_uses_rt = 1'b0;
    ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_rd = '0;
    mem_reg_write = 1'b0; mem_mem_read = 1'b0; mem_rd = '0;
    wb_reg_write = 1'b0; wb_rd = '0; bru_taken = 1'b0;
    m_br = '0; m_tk = '0; m_st = '0;
    repeat (2) @(posedge clk);

    step("reset", 0, 0, 0, 0, 0, P_NONE, 0, P_NONE, 0, 0, 0, 0, EV_NONE, 0, 0);

    // ALU r5 in EX, BEQ r5,r6: one stall, then forward from EX/MEM, taken.
    step("beq_det", 0, 1, 5, 6, 1, P_ALU, 5, P_NONE, 0, 0, 0, 0, EV_NONE, 0, 0);
    step("beq_stl", 0, 1, 5, 6, 1, P_NONE, 0, P_ALU, 5, 0, 0, 0, EV_STALL, 0, 0);
    step("beq_res", 0, 1, 5, 6, 1, P_NONE, 0, P_ALU, 5, 0, 0, 1, EV_RESOLVE, 2'b01, 2'b00);

    // LW r5 in EX, BGTZ r5 (rt ignored even though MEM writes it): two stalls.
    step("bgtz_det",  0, 1, 5, 7, 0, P_LOAD, 5, P_NONE, 0, 0, 0, 0, EV_NONE, 0, 0);
    step("bgtz_stl1", 0, 1, 5, 7, 0, P_NONE, 0, P_LOAD, 5, 0, 0, 0, EV_STALL, 0, 0);
    step("bgtz_stl2", 0, 1, 5, 7, 0, P_NONE, 0, P_NONE, 0, 1, 5, 0, EV_STALL, 0, 0);
    step("bgtz_res",  0, 1, 5, 7, 0, P_NONE, 0, P_ALU, 7, 1, 5, 0, EV_RESOLVE, 2'b10, 2'b00);

    // r0 never hazards nor forwards.
    step("bne_r0", 0, 1, 0, 0, 1, P_ALU, 0, P_ALU, 0, 1, 0, 0, EV_RESOLVE, 2'b00, 2'b00);

    // Forward priority: MEM non-load beats WB; back-to-back branches.
    step("fwd_mix",  0, 1, 8, 9, 1, P_NONE, 0, P_ALU, 8, 1, 9, 0, EV_RESOLVE, 2'b01, 2'b10);
    step("fwd_prio", 0, 1, 8, 8, 1, P_NONE, 0, P_ALU, 8, 1, 8, 1, EV_RESOLVE, 2'b01, 2'b01);

    // Max over operands: EX load on rs (2) vs MEM load on rt (1).
    step("max_det",  0, 1, 11, 12, 1, P_LOAD, 11, P_LOAD, 12, 0, 0, 0, EV_NONE, 0, 0);
    step("max_stl1", 0, 1, 11, 12, 1, P_NONE, 0, P_LOAD, 11, 1, 12, 0, EV_STALL, 0, 0);
    step("max_stl2", 0, 1, 11, 12, 1, P_NONE, 0, P_NONE, 0, 1, 11, 0, EV_STALL, 0, 0);
    step("max_res",  0, 1, 11, 12, 1, P_NONE, 0, P_NONE, 0, 1, 11, 1, EV_RESOLVE, 2'b10, 2'b00);

    // MEM load: single stall.
    step("mld_det", 0, 1, 10, 0, 0, P_NONE, 0, P_LOAD, 10, 0, 0, 0, EV_NONE, 0, 0);
    step("mld_stl", 0, 1, 10, 0, 0, P_NONE, 0, P_NONE, 0, 1, 10, 0, EV_STALL, 0, 0);
    step("mld_res", 0, 1, 10, 0, 0, P_NONE, 0, P_NONE, 0, 1, 10, 0, EV_RESOLVE, 2'b10, 2'b00);

    // BLTZ r3 behind a load, flushed after the first stall cycle.
    step("abt_det",  0, 1, 3, 0, 0, P_LOAD, 3, P_NONE, 0, 0, 0, 0, EV_NONE, 0, 0);
    step("abt_stl",  0, 1, 3, 0, 0, P_NONE, 0, P_LOAD, 3, 0, 0, 0, EV_STALL, 0, 0);
    step("abt_drop", 0, 0, 3, 0, 0, P_NONE, 0, P_NONE, 0, 1, 3, 1, EV_NONE, 0, 0);
    step("abt_idle", 0, 0, 0, 0, 0, P_NONE, 0, P_NONE, 0, 0, 0, 0, EV_NONE, 0, 0);

    // Reset while stalled.
    step("rst_det",  0, 1, 5, 0, 0, P_ALU, 5, P_NONE, 0, 0, 0, 0, EV_NONE, 0, 0);
    step("rst_stl",  0, 1, 5, 0, 0, P_NONE, 0, P_ALU, 5, 0, 0, 0, EV_STALL, 0, 0);
    step("rst_hit",  1, 1, 5, 0, 0, P_NONE, 0, P_ALU, 5, 0, 0, 1, EV_NONE, 0, 0);
    step("rst_after", 0, 0, 0, 0, 0, P_NONE, 0, P_NONE, 0, 0, 0, 0, EV_NONE, 0, 0);

    // Sixteen taken hazard-free branches saturate the 4-bit counters.
    for (int i = 0; i < 16; i++)
      step("sat_br", 0, 1, 1, 2, 1, P_NONE, 0, P_NONE, 0, 0, 0, 1, EV_RESOLVE, 2'b00, 2'b00);
    step("sat_end", 0, 0, 0, 0, 0, P_NONE, 0, P_NONE, 0, 0, 0, 0, EV_NONE, 0, 0);
    check("sat_final", "cnt_taken", 16'(cnt_taken), 16'd15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_ctrl.md
# branch_ctrl

Decode-stage branch controller for the pipelined MIPS core. It detects data hazards on branch operands and stalls the front end until operands are forwardable. It drives the enable and operand-forward selects for `Branch_Resolution_Unit`, and turns its `branch_taken` into a PC redirect plus IF/ID flush. It also keeps saturating branch statistics counters.

## Interface
Parameters:
- `REG_W`, 5, register-address width
- `STAT_W`, 16, statistics counter width

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  core clock
- `rst`  in  1  synchronous active-high reset
- `id_branch`  in  1  branch instruction valid in ID
- `id_rs`, `id_rt`  in  REG_W  branch source registers
- `id_uses_rt`  in  1  rt is compared (BEQ/BNE only)
- `ex_reg_write`, `ex_mem_read`  in  1  EX-stage producer flags
- `ex_rd`  in  REG_W  EX-stage destination
- `mem_reg_write`, `mem_mem_read`  in  1  MEM-stage producer flags
- `mem_rd`  in  REG_W  MEM-stage destination
- `wb_reg_write`  in  1  WB-stage write flag
- `wb_rd`  in  REG_W  WB-stage destination
- `bru_taken`  in  1  `branch_taken` from the resolution unit
- `bru_enable`  out  1  drives resolution-unit `branch` input
- `fwd_a_sel`, `fwd_b_sel`  out  2  operand source: 00 regfile, 01 EX/MEM ALU result, 10 MEM/WB result
- `stall_front`  out  1  hold PC and IF/ID
- `bubble_id_ex`  out  1  insert NOP into ID/EX
- `pc_sel_branch`  out  1  select branch target for next PC
- `flush_if_id`  out  1  squash the IF/ID instruction
- `cnt_branches`, `cnt_taken`, `cnt_stall_cycles`  out  STAT_W  saturating statistics

## Operation
- FSM states: IDLE, STALL, RESOLVE.
- Register 0 never causes a hazard or a forward. rt is ignored unless `id_uses_rt`.
- Required stall per operand, computed in IDLE:
  - EX producer, non-load, rd match: 1 cycle.
  - EX load, rd match: 2 cycles.
  - MEM load, rd match: 1 cycle.
  - Otherwise: 0.
  - Required stall is the maximum over the used operands.
- IDLE with `id_branch`:
  - Required stall 0: treat this cycle as RESOLVE (combinational; no state change).
  - Required stall > 0: load `stall_cnt` with it and go to STALL.
- STALL: `stall_front=1`, `bubble_id_ex=1`, `bru_enable=0`. `stall_cnt` decrements each cycle. When it reaches 1, the next state is RESOLVE.
- STALL with `id_branch` deasserted (external flush): abort to IDLE. No resolve happens and counters are untouched except stall cycles already counted.
- RESOLVE cycle:
  - `bru_enable=1`.
  - Forward select per operand, by priority: MEM producer non-load rd match gives 01; else WB producer rd match gives 10; else 00.
  - `bru_taken=1` gives `pc_sel_branch=1` and `flush_if_id=1` in the same cycle.
  - Next state is IDLE.
- Counters saturate at all-ones:
  - `cnt_branches` +1 per RESOLVE.
  - `cnt_taken` +1 per taken RESOLVE.
  - `cnt_stall_cycles` +1 per STALL cycle.

## Timing
- Reset: state IDLE, `stall_cnt=0`, all counters 0. All control outputs 0, `fwd_*_sel=00`.
- All control outputs are combinational from the state and inputs (Mealy); counters and state are registered.
- Latency from branch in ID to redirect: 0 cycles without hazard; 1 or 2 stall cycles otherwise. The redirect is always in the RESOLVE cycle.
- A branch following a branch: after RESOLVE the FSM returns to IDLE, so a new `id_branch` in the next cycle is evaluated normally.
- `rst` during STALL: IDLE next cycle, stall dropped, no resolve.
- `flush_if_id` and `stall_front` are never both 1.

## Structure
- Package `branch_ctrl_pkg`:
  - State enum `bctl_state_t`.
  - Forward-select enum `fwd_sel_t` with values FWD_RF, FWD_EXMEM, FWD_MEMWB.
  - Branch-code constants shared with the resolution unit: BEQ 0x03, BNE 0x04, BLEZ 0x07, BGTZ 0x0F, BGEZ 0x11, BLTZ 0x13.
- One combinational sub-module `branch_hazard_detect`: computes the required stall and forward selects per operand. It is instantiated once per operand.

## Test plan
- ALU writes r5 in EX; BEQ r5,r6 in ID → `stall_front` for 1 cycle, then RESOLVE with `fwd_a_sel=01`, `fwd_b_sel=00`. Equal operands → `pc_sel_branch=flush_if_id=1`, `cnt_stall_cycles=1`.
- LW to r5 in EX; BGTZ r5 → 2 stall cycles, then RESOLVE with `fwd_a_sel=10`. Operand 0 → not taken, `cnt_taken` unchanged.
- BNE r0,r0 with an EX producer writing r0 → no stall, `fwd_*=00`, not taken, `cnt_branches=1`.
- Load in EX writing r3; BLTZ r3; `id_branch` dropped after the first stall cycle → IDLE, `bru_enable` never 1, `cnt_branches=0`.
- `rst` asserted during STALL → all outputs 0 next cycle, counters 0.
- Preload counters near saturation (STAT_W=4, 15 taken branches) → 16th taken branch leaves `cnt_taken=15`.
